// File: rtl/sensor_poll_monitor.sv
// sensor_poll_monitor: round-robin poller for NUM_CH sensors sharing one read
// engine. It keeps the latest sample per channel, applies hysteresis alarms and
// selects a channel to show (alarm-priority lock, otherwise timed rotation).
//
// Optional build macro: SENSOR_POLL_ASCII_EN adds row1/row2 ASCII text outputs.
//
// Ports:
//   clk_1MHz    block clock
//   rst_n       asynchronous active-low reset
//   en          polling enable
//   rd_req      read request to the read engine (held until done/timeout)
//   rd_ch       channel being read
//   rd_done     one-cycle read-complete strobe
//   rd_data     sample, valid with rd_done
//   alarm       per-channel alarm state
//   any_alarm   OR of alarm
//   err_timeout sticky per-channel timeout flags
//   disp_ch     channel selected for display
//   disp_value  latest value of disp_ch
//   disp_alarm  alarm of disp_ch
//   disp_update one-cycle pulse when the display registers reload
//   row1/row2   (SENSOR_POLL_ASCII_EN) 16-character ASCII display rows
module sensor_poll_monitor #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned THRESH_HI = 100,
  parameter int unsigned THRESH_LO = 90,
  parameter int unsigned POLL_GAP  = 1000,
  parameter int unsigned TIMEOUT   = 5000,
  parameter int unsigned DISP_HOLD = 1000000,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_1MHz,
  input  logic              rst_n,
  input  logic              en,
  output logic              rd_req,
  output logic [CH_W-1:0]   rd_ch,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] alarm,
  output logic              any_alarm,
  output logic [NUM_CH-1:0] err_timeout,
  output logic [CH_W-1:0]   disp_ch,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_alarm,
  output logic              disp_update
`ifdef SENSOR_POLL_ASCII_EN
  ,
  output logic [127:0]      row1,
  output logic [127:0]      row2
`endif
);

  localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  // Terminal counts; a zero parameter degenerates to a single-cycle period.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((DISP_HOLD > 0) ? DISP_HOLD - 1 : 0);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] HI_V      = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0] LO_V      = DATA_W'(THRESH_LO);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t              state;
  logic [CH_W-1:0]     ptr;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   value [NUM_CH];

  logic                cap;
  logic [CH_W-1:0]     ptr_nxt;
  logic [DATA_W-1:0]   value_nxt [NUM_CH];
  logic [NUM_CH-1:0]   alarm_nxt;
  logic [CH_W-1:0]     lock_ch;
  logic [CH_W-1:0]     rot_ch;
  logic [CH_W-1:0]     sel_ch;
  logic [HOLD_W-1:0]   hold_nxt;
  logic                reload;
  logic                upd;
  logic [DATA_W-1:0]   sel_value;
  logic                sel_alarm;

  assign cap     = (state == REQ) && rd_done;
  assign ptr_nxt = (ptr == CH_LAST) ? '0 : ptr + CH_W'(1);

  // Post-capture view of the value store and hysteresis alarms.
  always_comb begin : capture_c
    alarm_nxt = alarm;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      value_nxt[i] = value[i];
      if (cap && rd_ch == CH_W'(i)) begin
        value_nxt[i] = rd_data;
        if (rd_data > HI_V)      alarm_nxt[i] = 1'b1;
        else if (rd_data < LO_V) alarm_nxt[i] = 1'b0;
      end
    end
  end

  // Display selection: alarm lock beats rotation; a capture landing in the
  // reload cycle is folded in by reading the post-capture values.
  always_comb begin : display_c
    logic found;
    found   = 1'b0;
    lock_ch = disp_ch;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (alarm[i] && !found) begin
        lock_ch = CH_W'(i);
        found   = 1'b1;
      end
    end
    rot_ch   = (disp_ch == CH_LAST) ? '0 : disp_ch + CH_W'(1);
    sel_ch   = disp_ch;
    reload   = 1'b0;
    hold_nxt = hold_cnt + HOLD_W'(1);
    if (any_alarm) begin
      hold_nxt = '0;
      if (lock_ch != disp_ch) begin
        sel_ch = lock_ch;
        reload = 1'b1;
      end
    end else if (hold_cnt == HOLD_LAST) begin
      hold_nxt = '0;
      sel_ch   = rot_ch;
      reload   = 1'b1;
    end
    upd       = reload || (cap && rd_ch == disp_ch);
    sel_value = '0;
    sel_alarm = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel_ch == CH_W'(i)) begin
        sel_value = value_nxt[i];
        sel_alarm = alarm_nxt[i];
      end
    end
  end

`ifdef SENSOR_POLL_ASCII_EN
  logic [127:0] row1_nxt;
  logic [127:0] row2_nxt;

  // Text for the row generator, built from the values about to be displayed.
  always_comb begin : ascii_c
    int unsigned v;
    logic [7:0]  digit;
    v        = 32'(sel_value);
    digit    = 8'(32'd48 + 32'(sel_ch));
    row1_nxt = sel_alarm ? {"CH", digit, " DANGER      "} : {"CH", digit, " SAFE        "};
    row2_nxt = {8'(32'd48 + (v / 1000) % 10), 8'(32'd48 + (v / 100) % 10),
                8'(32'd48 + (v / 10) % 10), 8'(32'd48 + v % 10), {12{8'h20}}};
  end
`endif

  // Poll FSM, value store, alarms and display registers.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      hold_cnt    <= '0;
      rd_req      <= 1'b0;
      rd_ch       <= '0;
      alarm       <= '0;
      any_alarm   <= 1'b0;
      err_timeout <= '0;
      disp_ch     <= '0;
      disp_value  <= '0;
      disp_alarm  <= 1'b0;
      disp_update <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) value[i] <= '0;
`ifdef SENSOR_POLL_ASCII_EN
      row1        <= {16{8'h20}};
      row2        <= {16{8'h20}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state   <= REQ;
            rd_req  <= 1'b1;
            rd_ch   <= ptr;
            tmo_cnt <= '0;
          end
        end
        REQ: begin
          if (rd_done) begin
            rd_req  <= 1'b0;
            state   <= GAP;
            gap_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_req  <= 1'b0;
            state   <= GAP;
            gap_cnt <= '0;
            for (int i = 0; i < int'(NUM_CH); i++)
              if (rd_ch == CH_W'(i)) err_timeout[i] <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            ptr <= ptr_nxt;
            if (en) begin
              state   <= REQ;
              rd_req  <= 1'b1;
              rd_ch   <= ptr_nxt;
              tmo_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      for (int i = 0; i < int'(NUM_CH); i++) value[i] <= value_nxt[i];
      alarm       <= alarm_nxt;
      any_alarm   <= |alarm_nxt;
      hold_cnt    <= hold_nxt;
      disp_update <= upd;
      if (upd) begin
        disp_ch    <= sel_ch;
        disp_value <= sel_value;
        disp_alarm <= sel_alarm;
`ifdef SENSOR_POLL_ASCII_EN
        row1       <= row1_nxt;
        row2       <= row2_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sensor_poll_monitor.sv
// Self-checking bench for sensor_poll_monitor with a small read-engine
// responder and a per-channel value/alarm/error reference model.
module tb_sensor_poll_monitor;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned PG  = 4;
  localparam int unsigned TO  = 20;
  localparam int unsigned DH  = 50;

  logic          clk_1MHz = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rd_req;
  logic [1:0]    rd_ch;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic [NCH-1:0] alarm;
  logic          any_alarm;
  logic [NCH-1:0] err_timeout;
  logic [1:0]    disp_ch;
  logic [DW-1:0] disp_value;
  logic          disp_alarm;
  logic          disp_update;
`ifdef SENSOR_POLL_ASCII_EN
  logic [127:0]  row1;
  logic [127:0]  row2;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: latest value, alarm and sticky error per channel, plus
  // the channel the next read should address.
  int m_val   [NCH];
  bit m_alarm [NCH];
  bit m_err   [NCH];
  int m_ptr;

  always #5 clk_1MHz = ~clk_1MHz;

  sensor_poll_monitor #(
    .NUM_CH(NCH), .DATA_W(DW), .THRESH_HI(100), .THRESH_LO(90),
    .POLL_GAP(PG), .TIMEOUT(TO), .DISP_HOLD(DH)
  ) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .en(en),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_done(rd_done), .rd_data(rd_data),
    .alarm(alarm), .any_alarm(any_alarm), .err_timeout(err_timeout),
    .disp_ch(disp_ch), .disp_value(disp_value), .disp_alarm(disp_alarm),
    .disp_update(disp_update)
`ifdef SENSOR_POLL_ASCII_EN
    , .row1(row1), .row2(row2)
`endif
  );

  function automatic logic [NCH-1:0] model_alarm();
    logic [NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[i] = m_alarm[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] model_err();
    logic [NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[i] = m_err[i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk_1MHz);
    rst_n = 1'b0; en = 1'b0; rd_done = 1'b0; rd_data = '0;
    @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NCH); i++) begin
      m_val[i] = 0; m_alarm[i] = 0; m_err[i] = 0;
    end
    m_ptr = 0;
  endtask

  // Responder for one read: waits for rd_req, answers after `delay` cycles or
  // never (timeout), optionally pulses a stray rd_done in the gap, and checks
  // the DUT against the model. Returns the channel that was read (-1 if none).
  task automatic serve(input int delay, input int data, input bit answer,
                       input bit garbage, output int ch_o);
    int t;
    int cnt;
    logic [1:0] ch;
    t = 0;
    while (rd_req !== 1'b1 && t < 400) begin
      @(negedge clk_1MHz);
      t++;
    end
    checks++;
    if (rd_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_wait: rd_req=%b required=1 after %0d cycles", rd_req, t);
      ch_o = -1;
      return;
    end
    ch = rd_ch;
    ch_o = int'(ch);
    checks++;
    if (int'(ch) != m_ptr) begin
      failures++;
      $display("FAIL rd_ch_seq: got %0d required %0d", ch, m_ptr);
    end
    if (answer) begin
      for (int k = 1; k < delay; k++) begin
        @(negedge clk_1MHz);
        checks++;
        if (rd_req !== 1'b1 || rd_ch !== ch) begin
          failures++;
          $display("FAIL req_stable: rd_req=%b rd_ch=%0d required 1/%0d", rd_req, rd_ch, ch);
        end
      end
      @(negedge clk_1MHz);
      rd_done = 1'b1;
      rd_data = DW'(data);
      @(negedge clk_1MHz);
      rd_done = 1'b0;
      rd_data = DW'($urandom);
      m_val[ch] = data;
      if (data > 100) m_alarm[ch] = 1'b1;
      else if (data < 90) m_alarm[ch] = 1'b0;
      checks++;
      if (rd_req !== 1'b0) begin
        failures++;
        $display("FAIL req_drop: rd_req=%b required 0", rd_req);
      end
      if (garbage) begin
        @(negedge clk_1MHz);
        rd_done = 1'b1;
        rd_data = 8'hFF;
        @(negedge clk_1MHz);
        rd_done = 1'b0;
      end
    end else begin
      cnt = 0;
      while (rd_req === 1'b1 && cnt < 100) begin
        @(negedge clk_1MHz);
        cnt++;
      end
      m_err[ch] = 1'b1;
      checks++;
      if (cnt != int'(TO)) begin
        failures++;
        $display("FAIL timeout_len: rd_req high %0d cycles required %0d", cnt, TO);
      end
    end
    m_ptr = (m_ptr + 1) % int'(NCH);
    checks++;
    if (alarm !== model_alarm() || any_alarm !== (|model_alarm())) begin
      failures++;
      $display("FAIL alarm: got %b/%b required %b/%b", alarm, any_alarm, model_alarm(), |model_alarm());
    end
    checks++;
    if (err_timeout !== model_err()) begin
      failures++;
      $display("FAIL err_timeout: got %b required %b", err_timeout, model_err());
    end
    checks++;
    if (disp_value !== DW'(m_val[disp_ch]) || disp_alarm !== m_alarm[disp_ch]) begin
      failures++;
      $display("FAIL disp_consistent: ch %0d value %0d alarm %b required %0d %b",
               disp_ch, disp_value, disp_alarm, m_val[disp_ch], m_alarm[disp_ch]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; rd_done = 1'b0; rd_data = '0;
    #12;
    checks++;
    if ({rd_req, rd_ch, alarm, any_alarm, err_timeout, disp_ch, disp_value, disp_alarm, disp_update} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req %b ch %0d alarm %b any %b err %b dch %0d dval %0d dal %b dupd %b",
               rd_req, rd_ch, alarm, any_alarm, err_timeout, disp_ch, disp_value, disp_alarm, disp_update);
    end
`ifdef SENSOR_POLL_ASCII_EN
    begin
      logic [127:0] sp;
      sp = {16{8'h20}};
      checks++;
      if (row1 !== sp || row2 !== sp) begin
        failures++;
        $display("FAIL reset_rows: row1 %h row2 %h required %h", row1, row2, sp);
      end
    end
`endif
    do_reset();
  endtask

  task automatic test_round_robin();
    int ch;
    int t;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(3, 10 * m_ptr, 1'b1, 1'b0, ch);
      checks++;
      if (ch != i % 4) begin
        failures++;
        $display("FAIL rr_order: read %0d got ch %0d required %0d", i, ch, i % 4);
      end
    end
    checks++;
    if (alarm !== 4'b0000) begin
      failures++;
      $display("FAIL rr_no_alarm: got %b required 0000", alarm);
    end
    en = 1'b0;
    t = 0;
    while (disp_ch !== 2'd2 && t < 300) begin
      @(negedge clk_1MHz);
      t++;
    end
    checks++;
    if (disp_ch !== 2'd2 || disp_value !== 8'd20) begin
      failures++;
      $display("FAIL rr_value2: disp_ch %0d value %0d required 2 / 20", disp_ch, disp_value);
    end
  endtask

  task automatic test_hysteresis();
    int seq   [3] = '{101, 95, 89};
    bit exp_a [3] = '{1'b1, 1'b1, 1'b0};
    int seen = 0;
    int iter = 0;
    int ch;
    int d;
    int cnt;
    logic [1:0] dch0;
    logic upd0;
    do_reset();
    en = 1'b1;
    while (seen < 3 && iter < 40) begin
      iter++;
      d = (m_ptr == 1) ? seq[seen] : int'($urandom_range(0, 89));
      serve(int'($urandom_range(1, 6)), d, 1'b1, (m_ptr != 1) && ($urandom_range(0, 1) == 1), ch);
      if (ch == 1) begin
        checks++;
        if (alarm[1] !== exp_a[seen]) begin
          failures++;
          $display("FAIL hyst_alarm: sample %0d alarm[1]=%b required %b", seq[seen], alarm[1], exp_a[seen]);
        end
        if (seen == 0) begin
          dch0 = disp_ch;
          upd0 = disp_update;
          @(negedge clk_1MHz);
          checks++;
          if (disp_ch !== 2'd1 || disp_value !== 8'd101 || disp_alarm !== 1'b1) begin
            failures++;
            $display("FAIL lock_in: ch %0d value %0d alarm %b required 1 / 101 / 1", disp_ch, disp_value, disp_alarm);
          end
          checks++;
          if ((dch0 == 2'd1 && upd0 !== 1'b1) || (dch0 != 2'd1 && disp_update !== 1'b1)) begin
            failures++;
            $display("FAIL lock_pulse: upd %b then %b with prior ch %0d, required a pulse", upd0, disp_update, dch0);
          end
        end else begin
          checks++;
          if (disp_update !== 1'b1 || disp_value !== DW'(seq[seen]) || disp_ch !== 2'd1) begin
            failures++;
            $display("FAIL shown_capture: upd %b value %0d ch %0d required 1 / %0d / 1",
                     disp_update, disp_value, disp_ch, seq[seen]);
          end
        end
        if (seen == 2) begin
          en = 1'b0;
          cnt = 0;
          while (disp_ch === 2'd1 && cnt < 200) begin
            @(negedge clk_1MHz);
            cnt++;
          end
          checks++;
          if (cnt != int'(DH) || disp_ch !== 2'd2) begin
            failures++;
            $display("FAIL resume_rotation: moved to %0d after %0d cycles required 2 after %0d", disp_ch, cnt, DH);
          end
        end
        seen++;
      end
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL hyst_reads: saw %0d ch1 reads required 3", seen);
    end
  endtask

  task automatic test_timeout();
    int ch;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) serve(2, int'($urandom_range(0, 89)), 1'b1, 1'b0, ch);
    serve(0, 0, 1'b0, 1'b0, ch);
    checks++;
    if (ch != 3 || err_timeout !== 4'b1000) begin
      failures++;
      $display("FAIL timeout_flag: ch %0d err %b required 3 / 1000", ch, err_timeout);
    end
    serve(2, 50, 1'b1, 1'b0, ch);
    checks++;
    if (ch != 0) begin
      failures++;
      $display("FAIL timeout_advance: next ch %0d required 0", ch);
    end
    for (int i = 0; i < 3; i++) serve(4, int'($urandom_range(0, 89)), 1'b1, 1'b1, ch);
    checks++;
    if (err_timeout !== 4'b1000) begin
      failures++;
      $display("FAIL timeout_sticky: err %b required 1000", err_timeout);
    end
  endtask

  task automatic test_rotation();
    int cnt;
    int ch;
    do_reset();
    cnt = 0;
    while (disp_ch === 2'd0 && cnt < 200) begin
      @(negedge clk_1MHz);
      cnt++;
    end
    checks++;
    if (cnt != int'(DH) || disp_ch !== 2'd1 || disp_update !== 1'b1) begin
      failures++;
      $display("FAIL rot_step1: ch %0d after %0d cycles upd %b required 1 after %0d upd 1", disp_ch, cnt, disp_update, DH);
    end
    @(negedge clk_1MHz);
    checks++;
    if (disp_update !== 1'b0) begin
      failures++;
      $display("FAIL rot_pulse_width: upd %b required 0", disp_update);
    end
    cnt = 0;
    while (disp_ch === 2'd1 && cnt < 200) begin
      @(negedge clk_1MHz);
      cnt++;
    end
    checks++;
    if (cnt != int'(DH) - 1 || disp_ch !== 2'd2) begin
      failures++;
      $display("FAIL rot_step2: ch %0d after %0d cycles required 2 after %0d", disp_ch, cnt, DH - 1);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++)
      serve(int'($urandom_range(1, 8)), (m_ptr == 0) ? 120 : (m_ptr == 2) ? 150 : 5, 1'b1, 1'($urandom_range(0, 1)), ch);
    @(negedge clk_1MHz);
    checks++;
    if (disp_ch !== 2'd0 || disp_value !== 8'd120 || disp_alarm !== 1'b1 || alarm !== 4'b0101) begin
      failures++;
      $display("FAIL lowest_alarm: ch %0d value %0d dal %b alarm %b required 0 / 120 / 1 / 0101",
               disp_ch, disp_value, disp_alarm, alarm);
    end
  endtask

  task automatic test_en_drop();
    int t;
    bit seen;
    do_reset();
    en = 1'b1;
    t = 0;
    while (rd_req !== 1'b1 && t < 50) begin
      @(negedge clk_1MHz);
      t++;
    end
    en = 1'b0;
    repeat (4) @(negedge clk_1MHz);
    checks++;
    if (rd_req !== 1'b1 || rd_ch !== 2'd0) begin
      failures++;
      $display("FAIL en_drop_hold: rd_req %b ch %0d required 1 / 0", rd_req, rd_ch);
    end
    @(negedge clk_1MHz);
    rd_done = 1'b1;
    rd_data = 8'd200;
    @(negedge clk_1MHz);
    rd_done = 1'b0;
    checks++;
    if (alarm !== 4'b0001 || rd_req !== 1'b0 || disp_value !== 8'd200) begin
      failures++;
      $display("FAIL en_drop_capture: alarm %b req %b dval %0d required 0001 / 0 / 200", alarm, rd_req, disp_value);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_1MHz);
      if (rd_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL en_drop_park: rd_req seen %b required 0", seen);
    end
    en = 1'b1;
    t = 0;
    while (rd_req !== 1'b1 && t < 50) begin
      @(negedge clk_1MHz);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_req, rd_ch, alarm, any_alarm, err_timeout, disp_ch, disp_value, disp_alarm, disp_update} !== '0) begin
      failures++;
      $display("FAIL async_reset: req %b alarm %b any %b err %b dch %0d dval %0d dal %b dupd %b required all 0",
               rd_req, alarm, any_alarm, err_timeout, disp_ch, disp_value, disp_alarm, disp_update);
    end
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_random();
    int ch;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 16; i++)
      serve(int'($urandom_range(1, 8)), int'($urandom_range(0, 255)), $urandom_range(0, 9) != 0,
            1'($urandom_range(0, 1)), ch);
  endtask

`ifdef SENSOR_POLL_ASCII_EN
  task automatic test_ascii();
    int ch;
    logic [127:0] e1;
    logic [127:0] e2;
    e1 = "CH2 DANGER      ";
    e2 = "0123            ";
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) serve(3, (m_ptr == 2) ? 123 : 5, 1'b1, 1'b0, ch);
    @(negedge clk_1MHz);
    checks++;
    if (disp_ch !== 2'd2 || row1 !== e1 || row2 !== e2) begin
      failures++;
      $display("FAIL ascii_rows: ch %0d row1 \"%s\" row2 \"%s\" required 2 \"%s\" \"%s\"", disp_ch, row1, row2, e1, e2);
    end
  endtask
`endif

  initial begin
    fork
      begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_round_robin();
    test_hysteresis();
    test_timeout();
    test_rotation();
    test_en_drop();
    test_random();
`ifdef SENSOR_POLL_ASCII_EN
    test_ascii();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_poll_monitor.md
Name: sensor_poll_monitor

Overview:
- Multi-channel successor to the single-sensor read-and-display path.
- Polls NUM_CH sensors round-robin through one shared read-engine handshake (rd_req/rd_done), which the I2C frame reader serves.
- Keeps the latest value per channel and applies hysteresis alarm thresholds.
- Drives a rotating, alarm-priority display selection that feeds the LCD row generator.

Parameters:
- NUM_CH, 4, number of sensor channels, range 1..10.
- DATA_W, 8, sensor sample width, range 1..13.
- THRESH_HI, 100, alarm sets when value > THRESH_HI.
- THRESH_LO, 90, alarm clears when value < THRESH_LO; must be <= THRESH_HI.
- POLL_GAP, 1000, idle cycles between consecutive channel reads.
- TIMEOUT, 5000, cycles rd_req may stay unanswered before the read is abandoned.
- DISP_HOLD, 1000000, cycles each channel is shown while no alarm is active.

Ports:
- clk_1MHz  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  polling enable.
- rd_req  out  1  read request to the read engine.
- rd_ch  out  CH_W  channel being read; CH_W = max(1, clog2(NUM_CH)).
- rd_done  in  1  one-cycle read-complete strobe.
- rd_data  in  DATA_W  sample; valid only in the rd_done cycle.
- alarm  out  NUM_CH  per-channel alarm state.
- any_alarm  out  1  OR of alarm.
- err_timeout  out  NUM_CH  sticky per-channel timeout flags.
- disp_ch  out  CH_W  channel selected for display.
- disp_value  out  DATA_W  latest value of disp_ch.
- disp_alarm  out  1  alarm[disp_ch].
- disp_update  out  1  one-cycle pulse when the display registers reload.

Behaviour:
- Reset values:
  - All outputs are 0.
  - All stored values are 0.
  - FSM is in IDLE; the channel pointer is 0.
  - Gap, timeout and hold counters are 0.
- FSM states IDLE, REQ, GAP:
  - IDLE: when en=1, go to REQ next cycle with rd_ch = pointer and rd_req=1.
  - REQ: rd_req and rd_ch are held stable.
    - If rd_done=1: capture rd_data into value[rd_ch], deassert rd_req next cycle, go to GAP.
    - Else if the timeout counter reaches TIMEOUT-1: deassert rd_req, set err_timeout[rd_ch], leave value and alarm unchanged, go to GAP.
  - GAP: count POLL_GAP cycles, advance the pointer, then return to REQ if en=1, otherwise to IDLE.
- Pointer wraps NUM_CH-1 -> 0.
- rd_done outside REQ is ignored.
- en deasserted while in REQ:
  - The transaction completes or times out normally; a request is never dropped mid-handshake.
  - The FSM then parks in IDLE after GAP.
- Latency: value and alarm update on the clock edge after the rd_done cycle.
- Alarm hysteresis, evaluated on each capture:
  - new > THRESH_HI -> 1.
  - new < THRESH_LO -> 0.
  - otherwise hold.
  - Unsigned compare at DATA_W width.
- err_timeout clears only on reset; a later successful read does not clear it.
- Display selection:
  - If any_alarm=1, disp_ch = lowest-index alarmed channel. Lock-in reloads immediately, in the cycle after the alarm set, and the hold counter resets.
  - If any_alarm=0, disp_ch advances by one (with wrap) every DISP_HOLD cycles.
  - When all alarms clear, rotation resumes from the currently shown channel with a fresh hold count.
- Each reload, and each capture for the displayed channel, updates disp_value/disp_alarm and pulses disp_update for one cycle.
- Simultaneous events:
  - Hold-period expiry and alarm set in the same cycle: the alarm lock wins.
  - A capture on the displayed channel in a reload cycle produces a single disp_update pulse carrying the new value.
- Reset asserted mid-transaction: rd_req drops asynchronously and all state returns to reset values.

Optional Feature:
- Macro: SENSOR_POLL_ASCII_EN.
- When defined, two extra outputs are added:
  - row1 [127:0]: "CHn SAFE" or "CHn DANGER", left-aligned and space-padded to 16 characters, where n is an ASCII digit.
  - row2 [127:0]: disp_value as 4 zero-padded decimal digits followed by 12 spaces.
- Both rows are registered, are updated in the same cycle as disp_update, and reset to 16 spaces.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=4, POLL_GAP=4, TIMEOUT=20, DISP_HOLD=50.
- Scenario 1: en=1, responder answers rd_done 3 cycles after each rd_req with data 10*ch -> rd_ch sequence 0,1,2,3,0; value[2]=20; alarm=0; rd_req held stable until done.
- Scenario 2: ch1 returns 101, then 95, then 89 -> alarm[1] is 1, 1, 0 (hysteresis); disp_ch locks to 1 one cycle after the first capture; disp_update pulses.
- Scenario 3: ch3 never answers -> rd_req drops after 20 cycles; err_timeout=4'b1000; pointer moves to 0; err_timeout stays set after later good reads.
- Scenario 4: no alarms, ch0 displayed -> disp_ch steps 0->1->2 every 50 cycles; ch2 and ch0 both over threshold -> disp_ch=0.
- Scenario 5: en dropped mid-REQ, rd_done after 5 cycles -> data captured, FSM enters IDLE, no further rd_req; rst_n pulsed during REQ -> rd_req=0 immediately and all outputs 0.
- Scenario 6 (SENSOR_POLL_ASCII_EN): ch2 value 123 with alarm set -> row1="CH2 DANGER      ", row2="0123            ".
